// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared definitions for the Wishbone round-robin arbiter:
//     - arb_state_t : FSM state encoding (WB_IDLE / WB_BUSY)
//     - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default bus widths
//   No ports (package).
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/wb_arbiter_rr_priority.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr_priority
//   Combinational rotate-and-find-first encoder. Returns a one-hot grant for
//   the first asserted request found when searching ptr+1, ptr+2, ... with
//   wrap from N-1 back to 0. The master at ptr itself is searched last.
// Ports:
//   i_req  [N-1:0]   request vector
//   i_ptr  [PW-1:0]  index of the most recently served master
//   o_gnt  [N-1:0]   one-hot grant, all zero when no request
// -----------------------------------------------------------------------------
module wb_arbiter_rr_priority #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic w_found;

  // Outer loop walks search order (distance from ptr); inner loop keeps all
  // bit selects constant so the structure unrolls into a plain priority mux.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_ptr) + k) % N))) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Round-robin Wishbone arbiter sharing one slave port among NMASTERS masters.
//   A grant is held for a whole bus cycle (m_cycle high), then the round-robin
//   pointer moves to the released master and one idle cycle follows.
//
// Handshake: a master requests by raising m_cycle[i] and holds it until it
//   is done; a transfer completes on any cycle where s_strobe and s_ack are
//   both high. Ungranted masters keep their requests held and see m_ack=0.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   Ack watchdog. A counter runs while the granted master strobes without
//   ack; on reaching TIMEOUT_CYCLES the master gets a 1-cycle m_err pulse,
//   s_cycle/s_strobe are forced low that cycle and the grant is released.
//   Without the macro m_err is tied low and BUSY waits indefinitely.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   m_address/m_writedata packed master buses, master i at [i*W +: W]
//   m_strobe/m_cycle/m_write  per-master Wishbone controls
//   m_readdata            slave read data broadcast to all masters
//   m_ack / m_err         routed to granted master only
//   m_grant               registered one-hot grant, 0 when idle
//   s_*                   slave-side Wishbone port
//   dbg_state             current FSM state
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NMASTERS       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NMASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NMASTERS*DATA_WIDTH-1:0] m_writedata,
  input  logic [NMASTERS-1:0]            m_strobe,
  input  logic [NMASTERS-1:0]            m_cycle,
  input  logic [NMASTERS-1:0]            m_write,
  output logic [DATA_WIDTH-1:0]          m_readdata,
  output logic [NMASTERS-1:0]            m_ack,
  output logic [NMASTERS-1:0]            m_err,
  output logic [NMASTERS-1:0]            m_grant,
  output logic [ADDR_WIDTH-1:0]          s_address,
  output logic [DATA_WIDTH-1:0]          s_writedata,
  input  logic [DATA_WIDTH-1:0]          s_readdata,
  output logic                           s_strobe,
  output logic                           s_cycle,
  output logic                           s_write,
  input  logic                           s_ack,
  output arb_state_t                     dbg_state
);

  localparam int PW = $clog2(NMASTERS);
  localparam logic [PW-1:0] PTR_RESET = PW'(NMASTERS - 1);

  arb_state_t          r_state;
  logic [NMASTERS-1:0] r_grant;
  logic [PW-1:0]       r_ptr;

  logic [NMASTERS-1:0]   w_next_gnt;
  logic [PW-1:0]         w_grant_idx;
  logic [ADDR_WIDTH-1:0] w_address;
  logic [DATA_WIDTH-1:0] w_writedata;
  logic                  w_cyc;
  logic                  w_stb;
  logic                  w_we;
  logic                  w_timeout;

  wb_arbiter_rr_priority #(
    .N  (NMASTERS),
    .PW (PW)
  ) u_rr (
    .i_req (m_cycle),
    .i_ptr (r_ptr),
    .o_gnt (w_next_gnt)
  );

  // Index of the granted master, loaded into the pointer on release.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (r_grant[i]) w_grant_idx = PW'(i);
    end
  end

  // Output mux. r_grant is all-zero outside BUSY, so idle outputs are 0.
  always_comb begin
    w_address   = '0;
    w_writedata = '0;
    w_cyc       = 1'b0;
    w_stb       = 1'b0;
    w_we        = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (r_grant[i]) begin
        w_address   = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_writedata = m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        w_cyc       = m_cycle[i];
        w_stb       = m_cycle[i] & m_strobe[i];
        w_we        = m_write[i];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd_cnt;

  assign w_timeout = (r_state == WB_BUSY) && (r_wd_cnt == CW'(TIMEOUT_CYCLES));

  // Counts cycles the current strobe has waited; any ack restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
    end else if ((r_state != WB_BUSY) || s_ack || w_timeout) begin
      r_wd_cnt <= '0;
    end else if (w_stb) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout = 1'b0;
`endif

  // Single FSM: grant register and pointer are its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WB_IDLE;
      r_grant <= '0;
      r_ptr   <= PTR_RESET;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (|m_cycle) begin
            r_grant <= w_next_gnt;
            r_state <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          // Release on cycle drop (or watchdog); pointer moves to this master.
          if (!w_cyc || w_timeout) begin
            r_state <= WB_IDLE;
            r_grant <= '0;
            r_ptr   <= w_grant_idx;
          end
        end
        default: begin
          r_state <= WB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign s_address   = w_address;
  assign s_writedata = w_writedata;
  assign s_cycle     = w_cyc & ~w_timeout;
  assign s_strobe    = w_stb & ~w_timeout;
  assign s_write     = w_we;
  assign m_readdata  = s_readdata;
  assign m_ack       = r_grant & {NMASTERS{s_ack}};
  assign m_err       = r_grant & {NMASTERS{w_timeout}};
  assign m_grant     = r_grant;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int RW = 103;
  localparam int ACK_BUDGET = 50;
  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] ma [3];
  logic [31:0] md [3];
  logic [95:0] m_address;
  logic [95:0] m_writedata;
  logic [2:0]  m_strobe, m_cycle, m_write;
  logic [31:0] m_readdata;
  logic [2:0]  m_ack, m_err, m_grant;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_strobe, s_cycle, s_write, s_ack;
  arb_state_t  dbg_state;

  assign m_address   = {ma[2], ma[1], ma[0]};
  assign m_writedata = {md[2], md[1], md[0]};
  // Slave model read data: a fixed function of the presented address.
  assign s_readdata  = s_address ^ RD_KEY;

  wb_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .NMASTERS       (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_strobe    (m_strobe),
    .m_cycle     (m_cycle),
    .m_write     (m_write),
    .m_readdata  (m_readdata),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_grant     (m_grant),
    .s_address   (s_address),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .s_strobe    (s_strobe),
    .s_cycle     (s_cycle),
    .s_write     (s_write),
    .s_ack       (s_ack),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [2:0]    gexp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;
  logic ack_en;
  logic ack_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {grant, ack, write, address, writedata, readdata}
  task automatic push_x(input logic [1:0] m, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [2:0] oh;
    oh = 3'b001 << m;
    exp_q.push_back({oh, oh, we, a, d, a ^ RD_KEY});
  endtask

  task automatic push_g(input logic [2:0] g);
    gexp_q.push_back(g);
  endtask

  // ---------------- slave model ----------------
  // Registered ack: one cycle after an unacked strobe is seen.
  initial begin
    logic w;
    s_ack = 1'b0;
    forever begin
      @(negedge clk);
      w = (s_strobe && !s_ack && ack_en) || ack_force;
      @(posedge clk);
      #1;
      s_ack = w;
    end
  end

  // ---------------- monitor ----------------
  logic [RW-1:0] mon_act, mon_exp;
  logic [2:0]    prev_grant = 3'b000;
  logic [2:0]    gexp;

  always @(negedge clk) begin
    if (s_strobe && s_ack) begin
      mon_act = {m_grant, m_ack, s_write, s_address, s_writedata, m_readdata};
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL xfer_unexpected: got %h, expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_mismatched++;
          $display("FAIL xfer: got g=%b ack=%b we=%b a=%h wd=%h rd=%h, expected g=%b ack=%b we=%b a=%h wd=%h rd=%h",
                   mon_act[102:100], mon_act[99:97], mon_act[96], mon_act[95:64], mon_act[63:32], mon_act[31:0],
                   mon_exp[102:100], mon_exp[99:97], mon_exp[96], mon_exp[95:64], mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
    if (m_grant !== prev_grant) begin
      n_compared++;
      if (gexp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL grant_unexpected: got %b, expected no change", m_grant);
      end else begin
        gexp = gexp_q.pop_front();
        if (m_grant !== gexp) begin
          n_mismatched++;
          $display("FAIL grant_seq: got %b, expected %b", m_grant, gexp);
        end
      end
      prev_grant = m_grant;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 with the cycle dropped for one edge.
  task automatic master_run(input logic [1:0] idx, input int nstr, input logic we,
                            input logic [31:0] a0, input logic [31:0] d0);
    int waited;
    m_cycle[idx]  = 1'b1;
    m_strobe[idx] = 1'b1;
    m_write[idx]  = we;
    for (int s = 0; s < nstr; s++) begin
      ma[idx] = a0 + 32'(4 * s);
      md[idx] = d0 + 32'(s);
      waited  = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!m_ack[idx] && waited < ACK_BUDGET);
      if (!m_ack[idx]) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL ack_wait m%0d: got no ack after %0d cycles, expected ack", idx, waited);
      end
      @(posedge clk);
      #1;
    end
    m_cycle[idx]  = 1'b0;
    m_strobe[idx] = 1'b0;
    m_write[idx]  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [2:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_grant !== g && n < ACK_BUDGET);
    check(name, 32'(m_grant), 32'(g));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(m_grant), 32'd0);
    check({tag, "_ack"},   32'(m_ack),   32'd0);
    check({tag, "_err"},   32'(m_err),   32'd0);
    check({tag, "_scyc"},  32'(s_cycle), 32'd0);
    check({tag, "_sstb"},  32'(s_strobe), 32'd0);
    check({tag, "_swe"},   32'(s_write), 32'd0);
    check({tag, "_saddr"}, s_address,    32'd0);
    check({tag, "_swd"},   s_writedata,  32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(WB_IDLE));
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    m_cycle   = '0;
    m_strobe  = '0;
    m_write   = '0;
    ack_en    = 1'b1;
    ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ma[i] = '0;
      md[i] = '0;
    end

    // Reset held 10 cycles with masters idle.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    @(posedge clk); #1;

    // Three-way contention from reset pointer: 0,1,2 then 0 again.
    push_g(3'b001); push_g(3'b000); push_g(3'b010); push_g(3'b000);
    push_g(3'b100); push_g(3'b000); push_g(3'b001); push_g(3'b000);
    push_x(2'd0, 1'b1, 32'h100, 32'h11);
    push_x(2'd1, 1'b0, 32'h200, 32'h22);
    push_x(2'd2, 1'b1, 32'h300, 32'h33);
    push_x(2'd0, 1'b1, 32'h104, 32'h12);
    fork
      begin
        master_run(2'd0, 1, 1'b1, 32'h100, 32'h11);
        master_run(2'd0, 1, 1'b1, 32'h104, 32'h12);
      end
      master_run(2'd1, 1, 1'b0, 32'h200, 32'h22);
      master_run(2'd2, 1, 1'b1, 32'h300, 32'h33);
    join

    // Master 0 holds 4 strobes; master 1 pulses a request and leaves
    // (must be skipped); master 2 waits for master 0 to release.
    push_g(3'b001); push_g(3'b000); push_g(3'b100); push_g(3'b000);
    for (int s = 0; s < 4; s++) push_x(2'd0, 1'b1, 32'h400 + 32'(4 * s), 32'h40 + 32'(s));
    push_x(2'd2, 1'b1, 32'h500, 32'h55);
    fork
      master_run(2'd0, 4, 1'b1, 32'h400, 32'h40);
      begin
        wait_grant("hold_grant_m0", 3'b001);
        @(posedge clk); #1;
        m_cycle[1]  = 1'b1;
        m_strobe[1] = 1'b1;
        ma[1]       = 32'h777;
        repeat (2) begin @(posedge clk); #1; end
        m_cycle[1]  = 1'b0;
        m_strobe[1] = 1'b0;
        master_run(2'd2, 1, 1'b1, 32'h500, 32'h55);
      end
    join

    // Single master 1 write: one-cycle grant latency, slave port muxing.
    push_g(3'b010); push_g(3'b000);
    push_x(2'd1, 1'b1, 32'h10, 32'hA5);
    m_cycle[1]  = 1'b1;
    m_strobe[1] = 1'b1;
    m_write[1]  = 1'b1;
    ma[1]       = 32'h10;
    md[1]       = 32'hA5;
    @(negedge clk);
    check("lat_grant", 32'(m_grant), 32'd0);
    check("lat_scyc", 32'(s_cycle), 32'd0);
    @(negedge clk);
    check("m1_grant", 32'(m_grant), 32'b010);
    check("m1_scyc", 32'(s_cycle), 32'd1);
    check("m1_sstb", 32'(s_strobe), 32'd1);
    check("m1_swe", 32'(s_write), 32'd1);
    check("m1_saddr", s_address, 32'h10);
    check("m1_swd", s_writedata, 32'hA5);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_ack[1] && n < ACK_BUDGET);
      check("m1_ack", 32'(m_ack), 32'b010);
    end
    @(posedge clk); #1;
    m_cycle[1]  = 1'b0;
    m_strobe[1] = 1'b0;
    m_write[1]  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Stray slave ack while idle is not routed.
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_ack_route", 32'(m_ack), 32'd0);
    check("idle_ack_grant", 32'(m_grant), 32'd0);
    @(posedge clk); #1;

    // Master 0 transfer moves the pointer to 0; master 1 then gets reset
    // mid-strobe. After reset master 0 must win the 3-way tie.
    push_g(3'b001); push_g(3'b000);
    push_x(2'd0, 1'b0, 32'h580, 32'h58);
    master_run(2'd0, 1, 1'b0, 32'h580, 32'h58);
    push_g(3'b010); push_g(3'b000);
    ack_en      = 1'b0;
    m_cycle[1]  = 1'b1;
    m_strobe[1] = 1'b1;
    ma[1]       = 32'h600;
    wait_grant("pre_rst_grant", 3'b010);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_rst_scyc", 32'(s_cycle), 32'd0);
    check("async_rst_sstb", 32'(s_strobe), 32'd0);
    check("async_rst_grant", 32'(m_grant), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(WB_IDLE));
    @(posedge clk); #1;
    m_cycle[1]  = 1'b0;
    m_strobe[1] = 1'b0;
    ack_en      = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    push_g(3'b001); push_g(3'b000); push_g(3'b010); push_g(3'b000);
    push_g(3'b100); push_g(3'b000);
    push_x(2'd0, 1'b1, 32'h700, 32'h70);
    push_x(2'd1, 1'b1, 32'h704, 32'h71);
    push_x(2'd2, 1'b0, 32'h708, 32'h72);
    fork
      master_run(2'd0, 1, 1'b1, 32'h700, 32'h70);
      master_run(2'd1, 1, 1'b1, 32'h704, 32'h71);
      master_run(2'd2, 1, 1'b0, 32'h708, 32'h72);
    join

    // Slave never acks.
    push_g(3'b010); push_g(3'b000);
    ack_en      = 1'b0;
    m_cycle[1]  = 1'b1;
    m_strobe[1] = 1'b1;
    ma[1]       = 32'h800;
    wait_grant("noack_grant", 3'b010);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("wd_err_early", 32'(m_err), 32'd0);
    end
    @(negedge clk);
    check("wd_err_pulse", 32'(m_err), 32'b010);
    check("wd_scyc_forced", 32'(s_cycle), 32'd0);
    check("wd_sstb_forced", 32'(s_strobe), 32'd0);
    @(posedge clk); #1;
    m_cycle[1]  = 1'b0;
    m_strobe[1] = 1'b0;
    @(negedge clk);
    check("wd_err_clear", 32'(m_err), 32'd0);
    check("wd_grant_clear", 32'(m_grant), 32'd0);
`else
    repeat (20) begin
      @(negedge clk);
      check("noack_err", 32'(m_err), 32'd0);
    end
    check("noack_hold", 32'(m_grant), 32'b010);
    @(posedge clk); #1;
    m_cycle[1]  = 1'b0;
    m_strobe[1] = 1'b0;
`endif
    ack_en = 1'b1;
    repeat (5) @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("gexp_q_empty", 32'(gexp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
